// File: rtl/time_set_pkg.sv
// -----------------------------------------------------------------------------
// time_set_pkg
// Shared constants and types for the keypad time-setting front end.
//   - key codes recognised on the key strobe interface (digits are 0-9)
//   - BLANK digit code, shown by decode7 as an unlit digit
//   - range limits for committed hours and minutes
//   - state encoding for the entry FSM
// -----------------------------------------------------------------------------
package time_set_pkg;

    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_ENTER = 4'hE;
    localparam logic [3:0] BLANK     = 4'hF;

    localparam logic [6:0] HH_MAX = 7'd23;
    localparam logic [6:0] MM_MAX = 7'd59;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Key codes 0-9 are digits; everything above is a command or unused.
    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd2_to_bin.sv
// -----------------------------------------------------------------------------
// bcd2_to_bin
// Combinational conversion of a two-digit BCD number to binary.
// Ports:
//   tens  - BCD tens digit (0-9)
//   units - BCD units digit (0-9)
//   bin   - tens*10 + units, 0-99
// -----------------------------------------------------------------------------
module bcd2_to_bin (
    input  logic [3:0] tens,
    input  logic [3:0] units,
    output logic [6:0] bin
);

    assign bin = ({3'b000, tens} * 7'd10) + {3'b000, units};

endmodule

// File: rtl/time_set_entry.sv
// -----------------------------------------------------------------------------
// time_set_entry
// Keypad-driven time-setting front end. Collects four BCD digits (HHMM),
// range-checks them and writes the result to the RTC initial-time load port.
// Ports:
//   clk, rst            - system clock, asynchronous active-high reset
//   key_valid, key_code - one-cycle key strobe; 0-9 digit, C clear, E enter
//   initial_time_hh/mm  - last committed time, held until the next commit
//   initial_time_valid  - one-cycle commit strobe to the RTC
//   entry_err           - one-cycle error strobe (short entry or out of range)
//   entry_active        - high while a partial entry is held
//   digit3..digit0      - digits entered so far, BLANK where not yet entered
//   digit_cnt           - number of digits entered, 0-4
// -----------------------------------------------------------------------------
module time_set_entry
    import time_set_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 500000000,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            key_valid,
    input  logic [3:0]      key_code,
    output logic [4:0]      initial_time_hh,
    output logic [5:0]      initial_time_mm,
    output logic            initial_time_valid,
    output logic            entry_err,
    output logic            entry_active,
    output logic [3:0]      digit3,
    output logic [3:0]      digit2,
    output logic [3:0]      digit1,
    output logic [3:0]      digit0,
    output logic [2:0]      digit_cnt
);

    // The counter reaching TIMEOUT_CYCLES-1 abandons the entry, so the last
    // silent cycle that still keeps it is the one where it holds TIMEOUT-2.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);

    state_t          state;
    logic [TO_W-1:0] to_cnt;

    logic [6:0] hh_bin;
    logic [6:0] mm_bin;

    logic is_key_digit;
    logic is_clear;
    logic is_enter;
    logic timed_out;
    logic time_ok;
    logic drop_entry;

    bcd2_to_bin u_hh_conv (
        .tens  (digit3),
        .units (digit2),
        .bin   (hh_bin)
    );

    bcd2_to_bin u_mm_conv (
        .tens  (digit1),
        .units (digit0),
        .bin   (mm_bin)
    );

    // Key decode and exit conditions. Every path back to IDLE blanks the
    // display, so the exits are gathered into drop_entry: CLEAR, a short
    // ENTER, a timeout with no competing key, and the single COMMIT cycle.
    always_comb begin
        is_key_digit = key_valid && is_digit(key_code);
        is_clear     = key_valid && (key_code == KEY_CLEAR);
        is_enter     = key_valid && (key_code == KEY_ENTER);
        timed_out    = (state == ENTRY) && !key_valid && (to_cnt == TO_LAST);
        time_ok      = (hh_bin <= HH_MAX) && (mm_bin <= MM_MAX);
        drop_entry   = (state == COMMIT) ||
                       ((state == ENTRY) &&
                        (is_clear || timed_out ||
                         (is_enter && (digit_cnt != 3'd4))));
    end

    // Entry FSM with all outputs registered. The strobes default low every
    // cycle so each is at most one cycle wide; COMMIT always returns to IDLE,
    // which keeps valid and err from ever appearing on consecutive cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            to_cnt             <= '0;
            initial_time_hh    <= '0;
            initial_time_mm    <= '0;
            initial_time_valid <= 1'b0;
            entry_err          <= 1'b0;
            entry_active       <= 1'b0;
            digit3             <= BLANK;
            digit2             <= BLANK;
            digit1             <= BLANK;
            digit0             <= BLANK;
            digit_cnt          <= '0;
        end else begin
            initial_time_valid <= 1'b0;
            entry_err          <= 1'b0;
            if (drop_entry) begin
                state        <= IDLE;
                entry_active <= 1'b0;
                to_cnt       <= '0;
                digit3       <= BLANK;
                digit2       <= BLANK;
                digit1       <= BLANK;
                digit0       <= BLANK;
                digit_cnt    <= '0;
                if ((state == COMMIT) && time_ok) begin
                    initial_time_hh    <= hh_bin[4:0];
                    initial_time_mm    <= mm_bin[5:0];
                    initial_time_valid <= 1'b1;
                end else if ((state == COMMIT) || is_enter) begin
                    entry_err <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (is_key_digit) begin
                            digit3       <= key_code;
                            digit_cnt    <= 3'd1;
                            to_cnt       <= '0;
                            state        <= ENTRY;
                            entry_active <= 1'b1;
                        end
                    end
                    ENTRY: begin
                        // Any strobe, even one that is otherwise ignored,
                        // counts as activity and restarts the timeout.
                        if (key_valid) begin
                            to_cnt <= '0;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                        if (is_key_digit && (digit_cnt != 3'd4)) begin
                            case (digit_cnt)
                                3'd1:    digit2 <= key_code;
                                3'd2:    digit1 <= key_code;
                                default: digit0 <= key_code;
                            endcase
                            digit_cnt <= digit_cnt + 3'd1;
                        end else if (is_enter) begin
                            // Short ENTER is handled by drop_entry, so four
                            // digits are present here.
                            state        <= COMMIT;
                            entry_active <= 1'b0;
                        end
                    end
                    default: begin
                        state        <= IDLE;
                        entry_active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/time_set_entry.md
Name: time_set_entry

Overview:
- Keypad-driven time-setting front end. Collects four BCD digits (HHMM) from a key strobe interface and checks that the time is in range.
- On a valid entry it drives the RTC initial-time load interface: initial_time_hh, initial_time_mm and a one-cycle initial_time_valid.
- It is the writer side of the RTC's time-load port.
- It echoes the digits entered so far as BCD, so existing decode7 instances can display them.

Parameters:
TIMEOUT_CYCLES, 500000000, idle cycles after the last accepted key before a partial entry is abandoned (minimum 2)
TO_W, $clog2(TIMEOUT_CYCLES), timeout counter width

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
key_valid  input  1  one-cycle strobe; key_code is valid while it is high
key_code  input  4  0-9 = digit, 4'hC = CLEAR, 4'hE = ENTER, other codes ignored
initial_time_hh  output  5  committed hours, 0-23
initial_time_mm  output  6  committed minutes, 0-59
initial_time_valid  output  1  one-cycle commit strobe to the RTC
entry_err  output  1  one-cycle error strobe
entry_active  output  1  high while a partial entry is held
digit3  output  4  first digit entered (hours tens); 4'hF = blank
digit2  output  4  hours units, or 4'hF
digit1  output  4  minutes tens, or 4'hF
digit0  output  4  minutes units, or 4'hF
digit_cnt  output  3  number of digits entered, 0-4

Behaviour:
- Reset (asynchronous, rst=1):
  - state IDLE; initial_time_hh=0, initial_time_mm=0.
  - initial_time_valid=0, entry_err=0, entry_active=0.
  - digit3..digit0=4'hF, digit_cnt=0, timeout counter 0.
  - Reset mid-entry or during COMMIT discards the entry; no strobe is issued.
- Key strobes: every cycle with key_valid=1 counts as one key. Upstream debounces and supplies single-cycle strobes.
- States: IDLE, ENTRY, COMMIT.
- IDLE:
  - digit key -> digit3=key, digit_cnt=1, go to ENTRY.
  - CLEAR, ENTER and unknown codes are ignored.
- ENTRY:
  - digit key with digit_cnt<4 -> written to the next position (digit2, then digit1, then digit0); digit_cnt+1.
  - digit key with digit_cnt=4 -> ignored; no overflow, no error.
  - CLEAR -> all digits blank, digit_cnt=0, go to IDLE.
  - ENTER with digit_cnt=4 -> go to COMMIT.
  - ENTER with digit_cnt<4 -> entry_err=1 in the following cycle; digits blank; go to IDLE.
- COMMIT lasts exactly one cycle:
  - hh_bin = digit3*10 + digit2 and mm_bin = digit1*10 + digit0, each a 7-bit intermediate.
  - If hh_bin<=23 and mm_bin<=59: initial_time_hh/mm load the truncated values and initial_time_valid=1 in the cycle after COMMIT.
  - Otherwise: entry_err=1 in the cycle after COMMIT and initial_time_hh/mm are unchanged.
  - Either way, digits blank, digit_cnt=0, go to IDLE.
  - key_valid during COMMIT is ignored.
- Latency: ENTER accepted at edge N -> COMMIT in cycle N+1 -> strobe high in cycle N+2 only.
- initial_time_hh/mm hold their last committed value indefinitely. The RTC samples them only while initial_time_valid=1.
- initial_time_valid and entry_err are mutually exclusive and never high for two consecutive cycles.
- entry_active=1 exactly when state=ENTRY.
- Timeout:
  - The counter clears on every accepted key and increments each ENTRY cycle.
  - On reaching TIMEOUT_CYCLES-1: go to IDLE with digits blanked; no strobe.
  - If a key arrives in the same cycle as the timeout, the key wins and the counter clears.
- All outputs are registered.

Decomposition:
- Package time_set_pkg holds:
  - key constants KEY_CLEAR=4'hC and KEY_ENTER=4'hE.
  - BLANK=4'hF.
  - HH_MAX=23 and MM_MAX=59.
  - the state enum (IDLE, ENTRY, COMMIT).
- Sub-module bcd2_to_bin: combinational; two BCD digits in, 7-bit binary out (tens*10 + units). Instantiated twice, for hours and minutes.

Test Plan:
1. Keys 1,2,3,4,ENTER -> initial_time_valid high exactly cycle N+2; hh=12, mm=34; digits return to 4'hF; digit_cnt=0.
2. After test 1, keys 2,4,0,0,ENTER -> entry_err pulse at N+2; no valid; hh/mm stay 12/34. Repeat with 1,2,6,0 -> same error result.
3. Keys 0,9,5,ENTER -> entry_err at N+1, state IDLE. Then 2,3,5,9,ENTER -> hh=23, mm=59, valid pulse.
4. Keys 1,2,CLEAR,0,7,3,0,9,ENTER -> fifth digit ignored; hh=7, mm=30. Also ENTER/CLEAR in IDLE -> no strobe, no state change.
5. TIMEOUT_CYCLES=16: key 1 then silence -> entry_active drops 15 cycles later, digits blank. Second run: a key in the timeout cycle keeps the entry; four digits then ENTER commit normally.
6. Assert rst mid-entry, and separately during the COMMIT cycle -> all outputs at reset values immediately; no valid or err strobe after release.
